// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, FSM encoding and latency bounds for the data-memory responder
package mem_pkg;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MERGE, S_WRITE, S_RESP, S_ERR} state_t;
  // code 11 behaves as a word access
  function automatic logic is_word(input logic [1:0] s);
    return s != SIZE_HALF && s != SIZE_BYTE;
  endfunction
  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] s);
    return is_word(s) ? |a : s == SIZE_HALF ? a[0] : 1'b0;
  endfunction
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: big-endian sub-word extract/extend and store-lane merge (combinational)
//  word   in  32  RAM word
//  wdata  in  32  right-justified store data
//  off    in  2   byte offset within the word
//  size   in  2   access size code
//  uns    in  1   zero-extend loads when set
//  rdata  out 32  extracted and extended load value
//  merged out 32  word with the addressed lane(s) replaced by wdata
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [4:0] sh;
  logic [31:0] mask;
  logic [15:0] lane;
  // offset 0 is the most significant lane, so the shift is taken from the inverted offset
  assign sh = size == SIZE_BYTE ? {~off, 3'b000} : size == SIZE_HALF ? {~off[1], 4'b0000} : 5'd0;
  assign mask = size == SIZE_BYTE ? 32'h0000_00ff : size == SIZE_HALF ? 32'h0000_ffff : 32'hffff_ffff;
  assign lane = 16'(word >> sh);
  assign rdata = size == SIZE_BYTE ? {{24{~uns & lane[7]}}, lane[7:0]} :
                 size == SIZE_HALF ? {{16{~uns & lane[15]}}, lane} : word;
  assign merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data RAM responder with programmable latency and sub-word access
//  Clk          in  1   clock, rising edge
//  Rst          in  1   asynchronous active-low reset
//  ReqValid     in  1   request present, held with Req* until RespValid
//  ReqReady     out 1   request accepted on an edge with ReqValid & ReqReady
//  ReqWrite     in  1   1 = store, 0 = load
//  ReqAddr      in  32  byte address
//  ReqWData     in  32  right-justified store data
//  ReqSize      in  2   00 word, 01 half, 10 byte, 11 word
//  ReqUnsigned  in  1   zero-extend loads
//  RespValid    out 1   one-cycle completion pulse
//  RespData     out 32  load result, 0 for stores and errors
//  AddrErr      out 1   misaligned access, pulses with RespValid
//  Stall        out 1   hold the pipeline until the response arrives
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [1:0]  ReqSize,
  input  logic        ReqUnsigned,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        AddrErr,
  output logic        Stall
);
  localparam int LAT = LATENCY < LAT_MIN ? LAT_MIN : LATENCY > LAT_MAX ? LAT_MAX : LATENCY;
  state_t state, nxt;
  logic [3:0] cnt;
  logic wr_q, uns_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0] wdata_q, word, rdata, merged;
  logic [1:0] size_q;
  logic accept;
  logic unused_addr;
  logic [31:0] mem [0:2**ADDR_W-1];
  assign unused_addr = ^ReqAddr[31:ADDR_W+2];
  // the response cycle itself still sees the old request on ReqValid, so it must not be re-accepted
  assign ReqReady = Rst & (state == S_IDLE) & ~RespValid;
  assign Stall = Rst & ReqValid & ~RespValid;
  assign accept = ReqValid & ReqReady;
  byte_lane_unit u_lane (
    .word(word), .wdata(wdata_q), .off(addr_q[1:0]), .size(size_q), .uns(uns_q),
    .rdata(rdata), .merged(merged)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept) nxt = misaligned(ReqAddr[1:0], ReqSize) ? S_ERR : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) nxt = !wr_q ? S_RESP : is_word(size_q) ? S_WRITE : S_MERGE;
      S_MERGE: nxt = S_WRITE;
      S_WRITE: nxt = S_RESP;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      wr_q <= 1'b0;
      uns_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= SIZE_WORD;
      RespValid <= 1'b0;
      RespData <= '0;
      AddrErr <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt <= 4'(LAT - 1);
        wr_q <= ReqWrite;
        uns_q <= ReqUnsigned;
        addr_q <= ReqAddr[ADDR_W+1:0];
        wdata_q <= ReqWData;
        size_q <= ReqSize;
      end else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      RespValid <= state == S_RESP || state == S_ERR;
      AddrErr <= state == S_ERR;
      RespData <= (state == S_RESP && !wr_q) ? rdata : 32'd0;
    end
  end
  // RAM side: word register doubles as read buffer and write-back data; a reset leaves
  // the state in IDLE, so no write can be issued for an aborted transaction
  always_ff @(posedge Clk) begin
    if (state == S_WAIT && cnt == 4'd0) word <= (wr_q && is_word(size_q)) ? wdata_q : mem[addr_q[ADDR_W+1:2]];
    if (state == S_MERGE) word <= merged;
    if (state == S_WRITE) mem[addr_q[ADDR_W+1:2]] <= word;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector bench for data_mem_responder (ADDR_W=10, LATENCY=2)
module tb_data_mem_responder;
  logic Clk = 0, Rst = 0, ReqValid = 0, ReqWrite = 0, ReqUnsigned = 0;
  logic [31:0] ReqAddr = 0, ReqWData = 0;
  logic [1:0] ReqSize = 0;
  logic ReqReady, RespValid, AddrErr, Stall;
  logic [31:0] RespData;
  int tests = 0, fails = 0;

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned),
    .RespValid(RespValid), .RespData(RespData), .AddrErr(AddrErr), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] data;
    logic        err;
    int          lat;
  } rec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // drive one request, count edges to RespValid (first edge is the accepting one)
  task automatic run(input rec_t r, input bit hold, input string nm);
    int n;
    bit sbad;
    ReqWrite = r.wr; ReqAddr = r.addr; ReqWData = r.wdata; ReqSize = r.size; ReqUnsigned = r.uns;
    ReqValid = 1;
    chk({nm, " ready"}, 32'(ReqReady), 32'd1);
    n = 0;
    sbad = 0;
    do begin
      @(posedge Clk); #1;
      n++;
      if (Stall !== (ReqValid & ~RespValid)) sbad = 1;
    end while (!RespValid && n < 40);
    chk({nm, " latency"}, 32'(n - 1), 32'(r.lat));
    chk({nm, " data"}, RespData, r.data);
    chk({nm, " err"}, 32'(AddrErr), 32'(r.err));
    chk({nm, " stall"}, 32'(sbad), 32'd0);
    if (!hold) ReqValid = 0;
    @(posedge Clk); #1;
    chk({nm, " pulse"}, 32'(RespValid), 32'd0);
  endtask

  rec_t v [$];

  initial begin
    v = '{
      '{1, 32'h10, 32'h8899AABB, 2'b00, 0, 32'h0,        0, 4},
      '{0, 32'h10, 32'h0,        2'b00, 0, 32'h8899AABB, 0, 3},
      '{0, 32'h10, 32'h0,        2'b10, 0, 32'hFFFFFF88, 0, 3},
      '{0, 32'h13, 32'h0,        2'b10, 1, 32'h000000BB, 0, 3},
      '{0, 32'h12, 32'h0,        2'b01, 0, 32'hFFFFAABB, 0, 3},
      '{0, 32'h10, 32'h0,        2'b01, 1, 32'h00008899, 0, 3},
      '{1, 32'h11, 32'h55,       2'b10, 0, 32'h0,        0, 5},
      '{0, 32'h10, 32'h0,        2'b00, 0, 32'h8855AABB, 0, 3},
      '{1, 32'h12, 32'h1234,     2'b01, 0, 32'h0,        0, 5},
      '{0, 32'h10, 32'h0,        2'b00, 0, 32'h88551234, 0, 3},
      '{0, 32'h12, 32'h0,        2'b00, 0, 32'h0,        1, 1},
      '{1, 32'h11, 32'hFFFF,     2'b01, 0, 32'h0,        1, 1},
      '{0, 32'h13, 32'h0,        2'b01, 1, 32'h0,        1, 1},
      '{0, 32'h10, 32'h0,        2'b00, 0, 32'h88551234, 0, 3},
      '{1, 32'h13, 32'hFFFFFF77, 2'b10, 0, 32'h0,        0, 5},
      '{0, 32'h10, 32'h0,        2'b11, 0, 32'h88551277, 0, 3},
      '{0, 32'h10, 32'h0,        2'b01, 0, 32'hFFFF8855, 0, 3},
      '{0, 32'h11, 32'h0,        2'b10, 0, 32'h00000055, 0, 3},
      '{0, 32'h13, 32'h0,        2'b10, 0, 32'h00000077, 0, 3},
      '{1, 32'h400, 32'hDEADBEEF, 2'b00, 0, 32'h0,       0, 4},
      '{0, 32'h402, 32'h0,       2'b01, 1, 32'h0000BEEF, 0, 3},
      '{0, 32'h10, 32'h0,        2'b00, 0, 32'h88551277, 0, 3}
    };
    ReqValid = 1;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset ready", 32'(ReqReady), 32'd0);
    chk("reset stall", 32'(Stall), 32'd0);
    chk("reset resp", {RespData[30:0], RespValid}, 32'd0);
    ReqValid = 0;
    @(negedge Clk) Rst = 1;
    #1;
    chk("post-reset ready", 32'(ReqReady), 32'd1);
    chk("post-reset err", 32'(AddrErr), 32'd0);
    foreach (v[i]) run(v[i], 0, $sformatf("vec%0d", i));

    // reset while an SB sits in WAIT: outputs clear at once and memory keeps the old word
    ReqWrite = 1; ReqAddr = 32'h10; ReqWData = 32'h00; ReqSize = 2'b10; ReqUnsigned = 0;
    ReqValid = 1;
    repeat (2) @(posedge Clk);
    #2 Rst = 0;
    #1;
    chk("abort ready", 32'(ReqReady), 32'd0);
    chk("abort stall", 32'(Stall), 32'd0);
    chk("abort outputs", {RespData[29:0], RespValid, AddrErr}, 32'd0);
    ReqValid = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Rst = 1;
    repeat (3) @(posedge Clk);
    #1;
    chk("abort ready after release", 32'(ReqReady), 32'd1);
    run('{0, 32'h10, 32'h0, 2'b00, 0, 32'h88551277, 0, 3}, 0, "abort lw");

    // ReqValid held across three requests, new fields after each response
    run('{0, 32'h10, 32'h0, 2'b00, 0, 32'h88551277, 0, 3}, 1, "b2b lw");
    run('{0, 32'h13, 32'h0, 2'b10, 1, 32'h00000077, 0, 3}, 1, "b2b lbu");
    run('{1, 32'h10, 32'h11, 2'b10, 0, 32'h0,       0, 5}, 0, "b2b sb");
    run('{0, 32'h10, 32'h0, 2'b00, 0, 32'h11551277, 0, 3}, 0, "b2b check");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
